// File: rtl/mul_float_pkg.sv
// mul_float_pkg: shared payload type, widths and buffer states for the float multiplier pipeline
package mul_float_pkg;
  localparam int BIAS = 127;
  localparam int EXP_W = 10;
  localparam int PROD_W = 48;
  localparam int SIG_W = 24;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [PROD_W-1:0] fract;
    logic except_exp_a0;
    logic except_exp_b0;
    logic except_exp_a1;
    logic except_exp_b1;
    logic except_fract_a0;
    logic except_fract_b0;
  } payload_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;
endpackage

// File: rtl/mul_float_rne_round.sv
// mul_float_rne_round: combinational normalize + round-to-nearest-even (din: raw product payload, dout: rounded payload)
module mul_float_rne_round
  import mul_float_pkg::*;
(
  input  payload_t din,
  output payload_t dout
);
  logic hi, g, s, up, carry;
  logic [SIG_W-1:0] sig;
  logic [SIG_W:0] sum;
  always_comb begin
    hi = din.fract[PROD_W-1];
    sig = hi ? din.fract[47:24] : din.fract[46:23];
    g = hi ? din.fract[23] : din.fract[22];
    s = hi ? |din.fract[22:0] : |din.fract[21:0];
    up = g & (s | sig[0]);
    sum = {1'b0, sig} + {{SIG_W{1'b0}}, up};
    carry = sum[SIG_W];
    dout = din;
    dout.exp = din.exp + {{(EXP_W-1){1'b0}}, hi} + {{(EXP_W-1){1'b0}}, carry};
    dout.fract = {carry ? {1'b1, {(SIG_W-1){1'b0}}} : sum[SIG_W-1:0], {(PROD_W-SIG_W){1'b0}}};
  end
endmodule

// File: rtl/mul_float_norm_round_rne.sv
// mul_float_norm_round_rne: 1-cycle normalize/RNE stage with valid/busy handshake and optional skid (iDATA_*: product beat in, oDATA_*: rounded beat out)
module mul_float_norm_round_rne
  import mul_float_pkg::*;
#(
  parameter bit P_SKID_EN = 1'b1
) (
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic iRESET_SYNC,
  input  logic iDATA_VALID,
  output logic oDATA_BUSY,
  input  logic iDATA_SIGN,
  input  logic [EXP_W-1:0] iDATA_EXP,
  input  logic [PROD_W-1:0] iDATA_FRACT,
  input  logic iDATA_EXCEPT_EXP_A0,
  input  logic iDATA_EXCEPT_EXP_B0,
  input  logic iDATA_EXCEPT_EXP_A1,
  input  logic iDATA_EXCEPT_EXP_B1,
  input  logic iDATA_EXCEPT_FRACT_A0,
  input  logic iDATA_EXCEPT_FRACT_B0,
  output logic oDATA_VALID,
  input  logic iDATA_BUSY,
  output logic oDATA_SIGN,
  output logic [EXP_W-1:0] oDATA_EXP,
  output logic [PROD_W-1:0] oDATA_FRACT,
  output logic oDATA_EXCEPT_EXP_A0,
  output logic oDATA_EXCEPT_EXP_B0,
  output logic oDATA_EXCEPT_EXP_A1,
  output logic oDATA_EXCEPT_EXP_B1,
  output logic oDATA_EXCEPT_FRACT_A0,
  output logic oDATA_EXCEPT_FRACT_B0
);
  payload_t in_p, rnd, out_r, skid_r;
  buf_state_t state, state_n;
  logic accept, consume, load_out, load_skid;
  assign in_p = {iDATA_SIGN, iDATA_EXP, iDATA_FRACT, iDATA_EXCEPT_EXP_A0, iDATA_EXCEPT_EXP_B0,
                 iDATA_EXCEPT_EXP_A1, iDATA_EXCEPT_EXP_B1, iDATA_EXCEPT_FRACT_A0, iDATA_EXCEPT_FRACT_B0};
  assign {oDATA_SIGN, oDATA_EXP, oDATA_FRACT, oDATA_EXCEPT_EXP_A0, oDATA_EXCEPT_EXP_B0, oDATA_EXCEPT_EXP_A1,
          oDATA_EXCEPT_EXP_B1, oDATA_EXCEPT_FRACT_A0, oDATA_EXCEPT_FRACT_B0} = out_r;
  mul_float_rne_round u_round (.din(in_p), .dout(rnd));
  assign oDATA_VALID = state != EMPTY;
  assign oDATA_BUSY = P_SKID_EN ? state == TWO : oDATA_VALID & iDATA_BUSY;
  assign accept = iDATA_VALID & ~oDATA_BUSY;
  assign consume = oDATA_VALID & ~iDATA_BUSY;
  always_comb begin
    state_n = state;
    load_out = 1'b0;
    load_skid = 1'b0;
    case (state)
      EMPTY: begin
        load_out = accept;
        state_n = accept ? ONE : EMPTY;
      end
      ONE: begin
        load_out = accept & consume;
        load_skid = P_SKID_EN & accept & ~consume;
        state_n = load_skid ? TWO : (consume & ~accept) ? EMPTY : ONE;
      end
      TWO: state_n = consume ? ONE : TWO;
      default: state_n = EMPTY;
    endcase
  end
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state <= EMPTY;
      out_r <= '0;
      skid_r <= '0;
    end else if (iRESET_SYNC) begin
      state <= EMPTY;
      out_r <= '0;
      skid_r <= '0;
    end else begin
      state <= state_n;
      if (load_out) out_r <= rnd;
      else if (state == TWO && consume) out_r <= skid_r;
      if (load_skid) skid_r <= rnd;
    end
  end
endmodule

// File: tb/tb_mul_float_norm_round_rne.sv
// tb_mul_float_norm_round_rne: randomized scoreboard bench with arithmetic rounding model and directed cases
module tb_mul_float_norm_round_rne;
  import mul_float_pkg::*;
  logic iCLOCK, inRESET, iRESET_SYNC, iDATA_VALID, oDATA_BUSY, iDATA_SIGN;
  logic [9:0] iDATA_EXP, oDATA_EXP;
  logic [47:0] iDATA_FRACT, oDATA_FRACT;
  logic [5:0] iflags, oflags;
  logic oDATA_VALID, iDATA_BUSY, oDATA_SIGN;
  int errors = 0, checks = 0;
  bit ds_rand = 0;
  payload_t q[$];
  mul_float_norm_round_rne #(.P_SKID_EN(1'b1)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iDATA_VALID(iDATA_VALID), .oDATA_BUSY(oDATA_BUSY),
    .iDATA_SIGN(iDATA_SIGN), .iDATA_EXP(iDATA_EXP), .iDATA_FRACT(iDATA_FRACT),
    .iDATA_EXCEPT_EXP_A0(iflags[5]), .iDATA_EXCEPT_EXP_B0(iflags[4]),
    .iDATA_EXCEPT_EXP_A1(iflags[3]), .iDATA_EXCEPT_EXP_B1(iflags[2]),
    .iDATA_EXCEPT_FRACT_A0(iflags[1]), .iDATA_EXCEPT_FRACT_B0(iflags[0]),
    .oDATA_VALID(oDATA_VALID), .iDATA_BUSY(iDATA_BUSY),
    .oDATA_SIGN(oDATA_SIGN), .oDATA_EXP(oDATA_EXP), .oDATA_FRACT(oDATA_FRACT),
    .oDATA_EXCEPT_EXP_A0(oflags[5]), .oDATA_EXCEPT_EXP_B0(oflags[4]),
    .oDATA_EXCEPT_EXP_A1(oflags[3]), .oDATA_EXCEPT_EXP_B1(oflags[2]),
    .oDATA_EXCEPT_FRACT_A0(oflags[1]), .oDATA_EXCEPT_FRACT_B0(oflags[0])
  );
  initial iCLOCK = 0;
  always #5 iCLOCK = ~iCLOCK;
  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  // Rounding expressed as integer division of the product by the LSB weight, with remainder vs. half.
  function automatic payload_t model(input payload_t p);
    payload_t m;
    int k;
    logic [48:0] qt;
    logic [47:0] r, half;
    logic [9:0] e;
    k = p.fract[47] ? 24 : 23;
    qt = {1'b0, p.fract >> k};
    r = p.fract & ((48'd1 << k) - 48'd1);
    half = 48'd1 << (k - 1);
    if (r > half || (r == half && qt[0])) qt = qt + 49'd1;
    e = p.exp + (p.fract[47] ? 10'd1 : 10'd0);
    if (qt == (49'd1 << 24)) begin
      qt = qt >> 1;
      e = e + 10'd1;
    end
    m = p;
    m.exp = e;
    m.fract = {qt[23:0], 24'h0};
    return m;
  endfunction
  function automatic payload_t cur_in();
    return {iDATA_SIGN, iDATA_EXP, iDATA_FRACT, iflags};
  endfunction
  function automatic payload_t cur_out();
    return {oDATA_SIGN, oDATA_EXP, oDATA_FRACT, oflags};
  endfunction
  // Occupancy model: beats accepted but not yet consumed, capacity two.
  always @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET || iRESET_SYNC) q.delete();
    else begin
      automatic bit m_acc = iDATA_VALID && q.size() < 2;
      automatic bit m_cons = q.size() > 0 && !iDATA_BUSY;
      if (m_cons) void'(q.pop_front());
      if (m_acc) q.push_back(model(cur_in()));
    end
  end
  always @(negedge iCLOCK) begin
    chk("valid", {79'd0, oDATA_VALID}, {79'd0, q.size() > 0});
    chk("busy", {79'd0, oDATA_BUSY}, {79'd0, q.size() == 2});
    if (q.size() > 0 && oDATA_VALID) chk("payload", {15'd0, cur_out()}, {15'd0, q[0]});
  end
  always @(negedge iCLOCK) if (ds_rand) iDATA_BUSY = $urandom_range(0, 9) < 4;
  task automatic drive(input payload_t p);
    {iDATA_SIGN, iDATA_EXP, iDATA_FRACT, iflags} = p;
  endtask
  task automatic send(input payload_t p);
    bit done;
    drive(p);
    iDATA_VALID = 1;
    done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(posedge iCLOCK);
      done = iDATA_VALID && !oDATA_BUSY;
    end
    if (!done) chk("accept_timeout", 80'd0, 80'd1);
    @(negedge iCLOCK);
  endtask
  task automatic idle(input int n);
    iDATA_VALID = 0;
    repeat (n) @(negedge iCLOCK);
  endtask
  function automatic payload_t mk(input logic s, input logic [9:0] e, input logic [47:0] f, input logic [5:0] fl);
    return {s, e, f, fl};
  endfunction
  function automatic payload_t rand_payload();
    logic [47:0] f;
    logic [23:0] a, b;
    bit hi;
    int mode;
    mode = $urandom_range(0, 3);
    f = {16'($urandom), $urandom};
    hi = 1'($urandom);
    f[47] = hi;
    if (!hi) f[46] = 1'b1;
    if (mode == 1) begin
      if (hi) f[22:0] = 23'd0;
      else f[21:0] = 22'd0;
    end else if (mode == 2) begin
      if (hi) f[47:24] = 24'hFFFFFF;
      else f[46:23] = 24'hFFFFFF;
    end else if (mode == 0) begin
      a = {1'b1, 23'($urandom)};
      b = {1'b1, 23'($urandom)};
      f = 48'(a) * 48'(b);
    end
    return mk(1'($urandom), 10'($urandom_range(0, 507)) - 10'd125, f, 6'($urandom));
  endfunction
  logic [47:0] dv_f[6] = '{48'h9000_0000_0000, 48'h4000_0000_0000, 48'h4000_00C0_0000,
                           48'h4000_0040_0000, 48'h4000_0040_0001, 48'h7FFF_FFC0_0000};
  logic [9:0] dv_ei[6] = '{10'd127, 10'd127, 10'd127, 10'd127, 10'd127, 10'd100};
  logic [9:0] dv_eo[6] = '{10'd128, 10'd127, 10'd127, 10'd127, 10'd127, 10'd101};
  logic [23:0] dv_s[6] = '{24'h900000, 24'h800000, 24'h800002, 24'h800000, 24'h800001, 24'h800000};
  initial begin
    payload_t p, m;
    inRESET = 0;
    iRESET_SYNC = 0;
    iDATA_BUSY = 0;
    iDATA_VALID = 0;
    drive('0);
    #1;
    chk("rst_valid", {79'd0, oDATA_VALID}, 80'd0);
    chk("rst_busy", {79'd0, oDATA_BUSY}, 80'd0);
    chk("rst_payload", {15'd0, cur_out()}, 80'd0);
    repeat (2) @(negedge iCLOCK);
    inRESET = 1;
    @(negedge iCLOCK);
    for (int i = 0; i < 6; i++) begin
      p = mk(i == 5, dv_ei[i], dv_f[i], i == 5 ? 6'b101101 : 6'b010010);
      m = model(p);
      chk("model_exp", {70'd0, m.exp}, {70'd0, dv_eo[i]});
      chk("model_sig", {56'd0, m.fract[47:24]}, {56'd0, dv_s[i]});
      send(p);
      chk("dut_exp", {70'd0, oDATA_EXP}, {70'd0, dv_eo[i]});
      chk("dut_fract", {32'd0, oDATA_FRACT}, {32'd0, dv_s[i], 24'h0});
      chk("dut_pass", {73'd0, oDATA_SIGN, oflags}, {73'd0, p.sign, p[5:0]});
    end
    idle(2);
    fork
      for (int i = 1; i <= 6; i++) send(mk(0, 10'd127, {2'b01, 6'(i), 40'd0}, 6'(i)));
      begin
        repeat (2) @(negedge iCLOCK);
        iDATA_BUSY = 1;
        repeat (3) @(negedge iCLOCK);
        iDATA_BUSY = 0;
      end
    join
    idle(4);
    iDATA_BUSY = 1;
    send(mk(0, 10'd10, 48'h4000_0000_0000, 6'd1));
    send(mk(0, 10'd11, 48'h4000_0000_0000, 6'd2));
    iDATA_VALID = 0;
    @(negedge iCLOCK);
    chk("stall_busy", {79'd0, oDATA_BUSY}, 80'd1);
    #2 inRESET = 0;
    #1;
    chk("async_valid", {79'd0, oDATA_VALID}, 80'd0);
    chk("async_busy", {79'd0, oDATA_BUSY}, 80'd0);
    @(negedge iCLOCK);
    inRESET = 1;
    iDATA_BUSY = 0;
    send(mk(1, 10'd50, 48'h9000_0000_0000, 6'd7));
    chk("post_rst_valid", {79'd0, oDATA_VALID}, 80'd1);
    chk("post_rst_exp", {70'd0, oDATA_EXP}, 80'd51);
    iDATA_BUSY = 1;
    send(mk(0, 10'd20, 48'h4000_0000_0000, 6'd3));
    iDATA_VALID = 0;
    @(negedge iCLOCK);
    iRESET_SYNC = 1;
    @(posedge iCLOCK);
    #1;
    chk("sync_valid", {79'd0, oDATA_VALID}, 80'd0);
    chk("sync_busy", {79'd0, oDATA_BUSY}, 80'd0);
    @(negedge iCLOCK);
    iDATA_BUSY = 0;
    drive(mk(0, 10'd30, 48'h4000_0000_0000, 6'd0));
    iDATA_VALID = 1;
    @(posedge iCLOCK);
    #1;
    chk("sync_over_accept", {79'd0, oDATA_VALID}, 80'd0);
    @(negedge iCLOCK);
    iRESET_SYNC = 0;
    iDATA_VALID = 0;
    @(negedge iCLOCK);
    ds_rand = 1;
    for (int i = 0; i < 400; i++) begin
      idle($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0);
      send(rand_payload());
    end
    idle(1);
    ds_rand = 0;
    iDATA_BUSY = 0;
    for (int n = 0; n < 10 && q.size() > 0; n++) @(negedge iCLOCK);
    chk("drain", {48'd0, 32'(q.size())}, 80'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mul_float_norm_round_rne.md
Name: mul_float_norm_round_rne

Overview:
Normalize-and-round stage of the single-precision float multiplier pipeline. It sits between the mantissa-product stage and the exception/pack stage, with 1-cycle latency.
- Consumes the raw 48-bit significand product and the provisional exponent.
- Normalizes, rounds to nearest-even and re-normalizes on carry-out.
- Passes sign and operand exception flags through unchanged.
- Provides a registered-busy skid buffer so the backpressure path is cut at this stage.

Parameters:
P_SKID_EN, 1, 1 = 2-entry (output + skid) buffer with registered oDATA_BUSY; 0 = single register, oDATA_BUSY = oDATA_VALID & iDATA_BUSY (combinational)

Ports:
iCLOCK  in  1  clock (one clock, rising edge)
inRESET  in  1  asynchronous, active-low reset
iRESET_SYNC  in  1  synchronous clear, active-high
iDATA_VALID  in  1  upstream beat present; held stable while oDATA_BUSY=1
oDATA_BUSY  out  1  stage cannot accept a beat this cycle
iDATA_SIGN  in  1  product sign
iDATA_EXP  in  10  provisional exponent expA+expB-127, two's complement
iDATA_FRACT  in  48  24x24 significand product, value in [1,4), binary point between bits 46/45
iDATA_EXCEPT_EXP_A0/B0/A1/B1, iDATA_EXCEPT_FRACT_A0/B0  in  1 each  operand exp all-0 / all-1, fract zero flags
oDATA_VALID  out  1  result beat present
iDATA_BUSY  in  1  downstream stall
oDATA_SIGN  out  1  passthrough
oDATA_EXP  out  10  normalized exponent, two's complement
oDATA_FRACT  out  48  rounded 24-bit significand (hidden bit) in [47:24], [23:0]=0
oDATA_EXCEPT_*  out  1 each  passthrough of the six flags

Behaviour:
- Handshake
  - Input accept: iDATA_VALID & ~oDATA_BUSY.
  - Output consume: oDATA_VALID & ~iDATA_BUSY.
- Reset
  - inRESET low: all outputs 0 immediately (oDATA_VALID=0, oDATA_BUSY=0); skid empty.
  - iRESET_SYNC high: same state at the next edge; it overrides any accept.
- Normalize
  - If fract[47]=1: sig=fract[47:24], G=fract[23], S=|fract[22:0], exp+1.
  - Else: sig=fract[46:23], G=fract[22], S=|fract[21:0], exp unchanged.
- Round (RNE): round up iff G & (S | sig[0]).
  - On carry-out (sig=0xFFFFFF rounding up): sig=0x800000, exp+1.
- Exponent arithmetic is 10-bit two's complement with no saturation. Valid-operand range is -125..382, so it cannot wrap. Overflow and underflow decisions belong to the exception stage.
- Round/normalize logic is combinational on the input; registers hold rounded results. Latency: accepted on edge N, visible on oDATA_VALID after edge N.
- Buffer states (P_SKID_EN=1): EMPTY, ONE (output reg full), TWO (output + skid full).
  - EMPTY: accept -> ONE.
  - ONE:
    - accept & consume -> ONE (new data).
    - accept & ~consume -> TWO (beat into skid).
    - consume only -> EMPTY.
    - neither -> hold.
  - TWO: oDATA_BUSY=1 (registered, equals state==TWO); no accept.
    - consume -> ONE (skid moves to output reg).
    - no consume -> hold.
  - Order is strictly preserved; no beat is lost or duplicated.
  - While stalled, outputs stay stable.
- P_SKID_EN=0: single register. It loads when (empty | consume) & accept and clears on consume without accept.

Decomposition:
- Package mul_float_pkg:
  - Payload typedef struct {sign, exp[9:0], fract[47:0], six except flags}, shared by the cal/norm/except stages.
  - Constants: BIAS=127, EXP_W=10, PROD_W=48, SIG_W=24.
- One combinational sub-module, mul_float_rne_round: payload in, rounded payload out.
- This module holds the buffer FSM and registers.

Test Plan:
- Normalize with shift: exp=127, fract=0x9000_0000_0000 (1.5*1.5) -> exp=128, fract[47:24]=0x900000.
- No shift: exp=127, fract=0x4000_0000_0000 -> exp=127, fract[47:24]=0x800000.
- RNE ties:
  - fract=0x4000_00C0_0000 -> sig 0x800002 (round up, odd LSB).
  - fract=0x4000_0040_0000 -> sig 0x800000 (tie stays even).
  - fract=0x4000_0040_0001 -> 0x800001 (sticky).
- Carry-out: exp=100, fract=0x7FFF_FFC0_0000 -> sig=0x800000, exp=101. Sign and flags pass unchanged.
- Backpressure: stream beats 1..6 back-to-back, iDATA_BUSY=1 for 3 cycles.
  - oDATA_BUSY=1 from the cycle after the skid fills.
  - Output sequence 1..6, no loss or duplication; oDATA_* stable while stalled.
- Reset mid-stall: state TWO, pull inRESET low -> oDATA_VALID=0, oDATA_BUSY=0 asynchronously. After release, first new beat emerges 1 cycle later. Repeat with iRESET_SYNC -> same state after one edge.
